// File: rtl/riscv_memory_lsu.sv
// RISC-V memory stage: request/grant/response data bus, byte lanes, load extension,
// misaligned/illegal access detection, M-stage stall and the MEM/WB pipeline register.
module riscv_memory_lsu #(
    parameter int XLEN = 32,
    parameter int AW   = 32,
    parameter int NB   = XLEN / 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid_m,
    input  logic            i_reg_write_m,
    input  logic [1:0]      i_result_src_m,
    input  logic            i_mem_read_m,
    input  logic            i_mem_write_m,
    input  logic [2:0]      i_funct3_m,
    input  logic [XLEN-1:0] i_alu_result_m,
    input  logic [XLEN-1:0] i_write_data_m,
    input  logic [4:0]      i_rd_m,
    input  logic [XLEN-1:0] i_pc_plus_4m,
    input  logic [XLEN-1:0] i_ext_imm_m,
    output logic            o_stall_m,
    output logic            o_bus_req,
    output logic            o_bus_wen,
    output logic [AW-1:0]   o_bus_addr,
    output logic [XLEN-1:0] o_bus_wdata,
    output logic [NB-1:0]   o_bus_be,
    input  logic            i_bus_gnt,
    input  logic            i_bus_rvalid,
    input  logic [XLEN-1:0] i_bus_rdata,
    output logic            o_valid_w,
    output logic            o_reg_write_w,
    output logic            o_fault_w,
    output logic [1:0]      o_result_src_w,
    output logic [XLEN-1:0] o_alu_result_w,
    output logic [XLEN-1:0] o_read_data_w,
    output logic [XLEN-1:0] o_pc_plus_4w,
    output logic [XLEN-1:0] o_ext_imm_w,
    output logic [4:0]      o_rd_w
);

    localparam int OW = $clog2(NB);

    typedef enum logic {IDLE, RESP} state_t;

    state_t          state;
    logic [1:0]      size;
    logic [OW-1:0]   off;
    logic            access;
    logic            illegal;
    logic            misaligned;
    logic            fault;
    logic            good;
    logic [NB-1:0]   be_base;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] aligned;
    logic [XLEN-1:0] sext_data;
    logic [XLEN-1:0] zext_data;
    logic [XLEN-1:0] load_data;
    int              sh;

    assign size   = i_funct3_m[1:0];
    assign off    = i_alu_result_m[OW-1:0];
    assign access = i_valid_m & (i_mem_read_m | i_mem_write_m);

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        illegal    = (i_funct3_m == 3'b111) ||
                     ((XLEN == 32) && ((i_funct3_m == 3'b011) || (i_funct3_m == 3'b110)));
        misaligned = 1'b0;
        case (size)
            2'b01:   misaligned = i_alu_result_m[0];
            2'b10:   misaligned = |i_alu_result_m[1:0];
            2'b11:   misaligned = |i_alu_result_m[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign fault = access & (illegal | misaligned);
    assign good  = access & ~fault;

    always_comb begin
        be_base     = '1;
        o_bus_wdata = i_write_data_m;
        case (size)
            2'b00: begin
                be_base     = NB'(1);
                o_bus_wdata = {NB{i_write_data_m[7:0]}};
            end
            2'b01: begin
                be_base     = NB'(3);
                o_bus_wdata = {(NB/2){i_write_data_m[15:0]}};
            end
            2'b10: begin
                be_base     = NB'(15);
                o_bus_wdata = {(NB/4){i_write_data_m[31:0]}};
            end
            default: begin
                be_base     = '1;
                o_bus_wdata = i_write_data_m;
            end
        endcase
    end

    assign o_bus_be   = be_base << off;
    assign o_bus_addr = {i_alu_result_m[AW-1:OW], {OW{1'b0}}};
    assign o_bus_wen  = i_mem_write_m;

    // Move the addressed lane to the top, then shift back down arithmetically or logically.
    always_comb begin
        sh = 0;
        case (size)
            2'b00:   sh = XLEN - 8;
            2'b01:   sh = XLEN - 16;
            2'b10:   sh = XLEN - 32;
            default: sh = 0;
        endcase
    end

    assign lane      = i_bus_rdata >> {off, 3'b000};
    assign aligned   = lane << sh;
    assign sext_data = $signed(aligned) >>> sh;
    assign zext_data = aligned >> sh;
    assign load_data = i_funct3_m[2] ? zext_data : sext_data;

    always_comb begin
        o_bus_req = 1'b0;
        o_stall_m = 1'b0;
        if (!i_rst) begin
            case (state)
                IDLE: begin
                    o_bus_req = good;
                    o_stall_m = good & ~(i_bus_gnt & i_mem_write_m);
                end
                RESP:    o_stall_m = ~i_bus_rvalid;
                default: o_stall_m = 1'b0;
            endcase
        end
    end

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            o_valid_w      <= 1'b0;
            o_reg_write_w  <= 1'b0;
            o_fault_w      <= 1'b0;
            o_result_src_w <= '0;
            o_alu_result_w <= '0;
            o_read_data_w  <= '0;
            o_pc_plus_4w   <= '0;
            o_ext_imm_w    <= '0;
            o_rd_w         <= '0;
        end else begin
            case (state)
                IDLE:    if (good && i_bus_gnt && !i_mem_write_m) state <= RESP;
                RESP:    if (i_bus_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (o_stall_m) begin
                o_valid_w     <= 1'b0;
                o_reg_write_w <= 1'b0;
                o_fault_w     <= 1'b0;
            end else begin
                o_valid_w      <= i_valid_m;
                o_reg_write_w  <= i_valid_m & i_reg_write_m & ~fault;
                o_fault_w      <= fault;
                o_result_src_w <= i_result_src_m;
                o_alu_result_w <= i_alu_result_m;
                o_read_data_w  <= (state == RESP) ? load_data : '0;
                o_pc_plus_4w   <= i_pc_plus_4m;
                o_ext_imm_w    <= i_ext_imm_m;
                o_rd_w         <= i_rd_m;
            end
        end
    end

endmodule

// File: tb/tb_riscv_memory_lsu.sv
// Scoreboard bench for riscv_memory_lsu: one XLEN=32 and one XLEN=64 instance share
// stimulus; monitors pop expected bus transactions and W-stage results as they appear.
module tb_riscv_memory_lsu;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid, wide, rw, mrd, mwr, gnt, rvalid;
    logic [1:0]  rsrc;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [63:0] alu, wd, pc4, imm, rdata;

    logic        stall32, req32, wen32, valid_w32, rw_w32, fault_w32;
    logic [31:0] addr32, wdata32, alu_w32, rdat_w32, pc4_w32, imm_w32;
    logic [3:0]  be32;
    logic [1:0]  rsrc_w32;
    logic [4:0]  rd_w32;

    logic        stall64, req64, wen64, valid_w64, rw_w64, fault_w64;
    logic [31:0] addr64;
    logic [63:0] wdata64, alu_w64, rdat_w64, pc4_w64, imm_w64;
    logic [7:0]  be64;
    logic [1:0]  rsrc_w64;
    logic [4:0]  rd_w64;

    riscv_memory_lsu #(.XLEN(32), .AW(32)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_valid_m(valid & ~wide), .i_reg_write_m(rw),
        .i_result_src_m(rsrc), .i_mem_read_m(mrd), .i_mem_write_m(mwr), .i_funct3_m(f3),
        .i_alu_result_m(alu[31:0]), .i_write_data_m(wd[31:0]), .i_rd_m(rd),
        .i_pc_plus_4m(pc4[31:0]), .i_ext_imm_m(imm[31:0]), .o_stall_m(stall32),
        .o_bus_req(req32), .o_bus_wen(wen32), .o_bus_addr(addr32), .o_bus_wdata(wdata32),
        .o_bus_be(be32), .i_bus_gnt(gnt), .i_bus_rvalid(rvalid), .i_bus_rdata(rdata[31:0]),
        .o_valid_w(valid_w32), .o_reg_write_w(rw_w32), .o_fault_w(fault_w32),
        .o_result_src_w(rsrc_w32), .o_alu_result_w(alu_w32), .o_read_data_w(rdat_w32),
        .o_pc_plus_4w(pc4_w32), .o_ext_imm_w(imm_w32), .o_rd_w(rd_w32)
    );

    riscv_memory_lsu #(.XLEN(64), .AW(32)) dut64 (
        .i_clk(clk), .i_rst(rst), .i_valid_m(valid & wide), .i_reg_write_m(rw),
        .i_result_src_m(rsrc), .i_mem_read_m(mrd), .i_mem_write_m(mwr), .i_funct3_m(f3),
        .i_alu_result_m(alu), .i_write_data_m(wd), .i_rd_m(rd),
        .i_pc_plus_4m(pc4), .i_ext_imm_m(imm), .o_stall_m(stall64),
        .o_bus_req(req64), .o_bus_wen(wen64), .o_bus_addr(addr64), .o_bus_wdata(wdata64),
        .o_bus_be(be64), .i_bus_gnt(gnt), .i_bus_rvalid(rvalid), .i_bus_rdata(rdata),
        .o_valid_w(valid_w64), .o_reg_write_w(rw_w64), .o_fault_w(fault_w64),
        .o_result_src_w(rsrc_w64), .o_alu_result_w(alu_w64), .o_read_data_w(rdat_w64),
        .o_pc_plus_4w(pc4_w64), .o_ext_imm_w(imm_w64), .o_rd_w(rd_w64)
    );

    // Outputs of whichever instance the current access targets.
    logic        stall_s, req_s, valid_w_s, fault_w_s;
    logic [63:0] addr_s, wdata_s;
    logic [7:0]  be_s;
    always_comb begin
        stall_s   = wide ? stall64   : stall32;
        req_s     = wide ? req64     : req32;
        valid_w_s = wide ? valid_w64 : valid_w32;
        fault_w_s = wide ? fault_w64 : fault_w32;
        addr_s    = wide ? {32'b0, addr64} : {32'b0, addr32};
        wdata_s   = wide ? wdata64   : {32'b0, wdata32};
        be_s      = wide ? be64      : {4'b0, be32};
    end

    typedef struct {
        logic        wen;
        logic [63:0] addr;
        logic [7:0]  be;
        logic [63:0] wdata;
    } bus_t;

    typedef struct {
        logic        rw;
        logic        fault;
        logic [4:0]  rd;
        logic [63:0] rdata;
        logic [63:0] alu;
        logic [63:0] pc4;
    } wb_t;

    bus_t bq32[$], bq64[$];
    wb_t  wq32[$], wq64[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got an output with no expected entry queued", name);
    endtask

    task automatic cmp_bus(input string t, input bus_t e, input logic wen, input logic [63:0] addr,
                           input logic [7:0] be, input logic [63:0] wdata);
        check({t, " wen"}, wen, e.wen);
        check({t, " addr"}, addr, e.addr);
        check({t, " be"}, be, e.be);
        if (e.wen) check({t, " wdata"}, wdata, e.wdata);
    endtask

    task automatic cmp_wb(input string t, input wb_t e, input logic rwv, input logic fault,
                          input logic [4:0] rdv, input logic [63:0] data, input logic [63:0] aluv,
                          input logic [63:0] pc4v);
        check({t, " reg_write"}, rwv, e.rw);
        check({t, " fault"}, fault, e.fault);
        check({t, " rd"}, rdv, e.rd);
        check({t, " read_data"}, data, e.rdata);
        check({t, " alu_result"}, aluv, e.alu);
        check({t, " pc_plus_4"}, pc4v, e.pc4);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (req32 && gnt) begin
                if (bq32.size() == 0) unexpected("bus32");
                else cmp_bus("bus32", bq32.pop_front(), wen32, {32'b0, addr32}, {4'b0, be32},
                             {32'b0, wdata32});
            end
            if (valid_w32) begin
                if (wq32.size() == 0) unexpected("w32");
                else cmp_wb("w32", wq32.pop_front(), rw_w32, fault_w32, rd_w32,
                            {32'b0, rdat_w32}, {32'b0, alu_w32}, {32'b0, pc4_w32});
            end
            if (req64 && gnt) begin
                if (bq64.size() == 0) unexpected("bus64");
                else cmp_bus("bus64", bq64.pop_front(), wen64, {32'b0, addr64}, be64, wdata64);
            end
            if (valid_w64) begin
                if (wq64.size() == 0) unexpected("w64");
                else cmp_wb("w64", wq64.pop_front(), rw_w64, fault_w64, rd_w64,
                            rdat_w64, alu_w64, pc4_w64);
            end
        end
    end

    task automatic set_m(input bit w, input bit v, input bit r, input bit s, input logic [2:0] fn,
                         input logic [63:0] a, input logic [63:0] d, input logic [4:0] rdi,
                         input bit regw);
        wide = w; valid = v; mrd = r; mwr = s; f3 = fn; alu = a; wd = d; rd = rdi;
        rw = regw; rsrc = 2'b01; pc4 = a + 64'h1000; imm = 64'h55;
    endtask

    task automatic idle_m();
        valid = 1'b0; mrd = 1'b0; mwr = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    endtask

    task automatic push(input bit w, input bus_t b, input bit has_bus, input wb_t x);
        if (w) begin
            if (has_bus) bq64.push_back(b);
            wq64.push_back(x);
        end else begin
            if (has_bus) bq32.push_back(b);
            wq32.push_back(x);
        end
    endtask

    task automatic do_load(input bit w, input logic [2:0] fn, input logic [63:0] a,
                           input logic [63:0] data, input logic [4:0] rdi, input int gw,
                           input int rv_wait, input logic [63:0] e_addr, input logic [7:0] e_be,
                           input logic [63:0] e_data);
        bit first;
        push(w, '{1'b0, e_addr, e_be, 64'h0}, 1'b1, '{1'b1, 1'b0, rdi, e_data, a, a + 64'h1000});
        set_m(w, 1'b1, 1'b1, 1'b0, fn, a, 64'h0, rdi, 1'b1);
        gnt = 1'b0;
        first = 1'b1;
        for (int i = 0; i < gw; i++) begin
            @(negedge clk);
            check("load stall before grant", stall_s, 1'b1);
            if (!first) check("load bubble in W", valid_w_s, 1'b0);
            first = 1'b0;
            @(posedge clk); #1;
        end
        gnt = 1'b1;
        @(negedge clk);
        check("load stall on grant", stall_s, 1'b1);
        check("load request on grant", req_s, 1'b1);
        if (!first) check("load bubble in W", valid_w_s, 1'b0);
        @(posedge clk); #1;
        gnt = 1'b0;
        for (int i = 0; i < rv_wait; i++) begin
            @(negedge clk);
            check("load stall awaiting rvalid", stall_s, 1'b1);
            check("no request awaiting rvalid", req_s, 1'b0);
            check("load bubble in W", valid_w_s, 1'b0);
            @(posedge clk); #1;
        end
        rvalid = 1'b1;
        rdata  = data;
        @(negedge clk);
        check("stall released on rvalid", stall_s, 1'b0);
        check("load bubble in W", valid_w_s, 1'b0);
        @(posedge clk); #1;
        idle_m();
        @(negedge clk);
        check("load reaches W after rvalid", valid_w_s, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic do_store(input bit w, input logic [2:0] fn, input logic [63:0] a,
                            input logic [63:0] d, input int gw, input logic [63:0] e_addr,
                            input logic [7:0] e_be, input logic [63:0] e_wdata);
        push(w, '{1'b1, e_addr, e_be, e_wdata}, 1'b1, '{1'b0, 1'b0, 5'd0, 64'h0, a, a + 64'h1000});
        set_m(w, 1'b1, 1'b0, 1'b1, fn, a, d, 5'd0, 1'b0);
        gnt = 1'b0;
        for (int i = 0; i < gw; i++) begin
            @(negedge clk);
            check("store req held", req_s, 1'b1);
            check("store addr held", addr_s, e_addr);
            check("store be held", be_s, e_be);
            check("store wdata held", wdata_s, e_wdata);
            check("store stall before grant", stall_s, 1'b1);
            @(posedge clk); #1;
        end
        gnt = 1'b1;
        @(negedge clk);
        check("store req on grant", req_s, 1'b1);
        check("store no stall on grant", stall_s, 1'b0);
        @(posedge clk); #1;
        idle_m();
        @(negedge clk);
        check("store reaches W", valid_w_s, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic do_fault(input bit w, input bit r, input bit s, input logic [2:0] fn,
                            input logic [63:0] a, input logic [4:0] rdi);
        push(w, '{1'b0, 64'h0, 8'h0, 64'h0}, 1'b0, '{1'b0, 1'b1, rdi, 64'h0, a, a + 64'h1000});
        set_m(w, 1'b1, r, s, fn, a, 64'hFFFF, rdi, 1'b1);
        gnt = 1'b1;
        @(negedge clk);
        check("fault no request", req_s, 1'b0);
        check("fault no stall", stall_s, 1'b0);
        @(posedge clk); #1;
        idle_m();
        @(negedge clk);
        check("fault flag in W", fault_w_s, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rdata = '0;
        idle_m();
        // A valid load with grant during reset must not reach the bus.
        set_m(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 64'h100, 64'h0, 5'd1, 1'b1);
        gnt = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset forces req low", req32, 1'b0);
        check("reset forces stall low", stall32, 1'b0);
        check("reset valid_w", valid_w32, 1'b0);
        check("reset read_data_w", rdat_w32, 32'h0);
        check("reset alu_result_w", alu_w64, 64'h0);
        @(posedge clk); #1;
        idle_m();
        rst = 1'b0;

        // XLEN=32 loads
        do_load(1'b0, 3'b010, 64'h100, 64'h8000_00F0, 5'd5, 0, 1, 64'h100, 8'h0F, 64'h8000_00F0);
        do_load(1'b0, 3'b000, 64'h103, 64'h8012_3456, 5'd6, 1, 0, 64'h100, 8'h08, 64'hFFFF_FF80);
        do_load(1'b0, 3'b100, 64'h103, 64'h8012_3456, 5'd7, 0, 0, 64'h100, 8'h08, 64'h0000_0080);
        do_load(1'b0, 3'b001, 64'h102, 64'h8012_3456, 5'd8, 0, 2, 64'h100, 8'h0C, 64'hFFFF_8012);
        do_load(1'b0, 3'b101, 64'h100, 64'h8012_3456, 5'd9, 2, 0, 64'h100, 8'h03, 64'h0000_3456);

        // XLEN=32 stores
        do_store(1'b0, 3'b001, 64'h102, 64'h0000_ABCD, 3, 64'h100, 8'h0C, 64'hABCD_ABCD);
        do_store(1'b0, 3'b000, 64'h101, 64'h0000_005A, 0, 64'h100, 8'h02, 64'h5A5A_5A5A);
        do_store(1'b0, 3'b010, 64'h104, 64'h1234_5678, 1, 64'h104, 8'h0F, 64'h1234_5678);

        // XLEN=32 faults
        do_fault(1'b0, 1'b1, 1'b0, 3'b010, 64'h102, 5'd10);
        do_fault(1'b0, 1'b1, 1'b0, 3'b011, 64'h100, 5'd11);
        do_fault(1'b0, 1'b0, 1'b1, 3'b001, 64'h101, 5'd12);
        do_fault(1'b0, 1'b1, 1'b0, 3'b111, 64'h100, 5'd13);
        do_fault(1'b0, 1'b1, 1'b0, 3'b110, 64'h100, 5'd14);

        // Reset while a load waits for its response
        bq32.push_back('{1'b0, 64'h200, 8'h0F, 64'h0});
        set_m(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 64'h200, 64'h0, 5'd9, 1'b1);
        gnt = 1'b1;
        @(negedge clk);
        check("pre-reset load stall", stall32, 1'b1);
        @(posedge clk); #1;
        gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("reset in RESP stall low", stall32, 1'b0);
        check("reset in RESP req low", req32, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_m(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 5'd0, 1'b0);
        rvalid = 1'b1;
        rdata  = 64'hDEAD_BEEF;
        @(negedge clk);
        check("late rvalid no stall", stall32, 1'b0);
        check("post-reset valid_w", valid_w32, 1'b0);
        check("post-reset reg_write_w", rw_w32, 1'b0);
        check("post-reset fault_w", fault_w32, 1'b0);
        check("post-reset rd_w", rd_w32, 5'd0);
        check("post-reset result_src_w", rsrc_w32, 2'b00);
        check("post-reset alu_result_w", alu_w32, 32'h0);
        check("post-reset pc_plus_4w", pc4_w32, 32'h0);
        check("post-reset ext_imm_w", imm_w32, 32'h0);
        @(posedge clk); #1;
        rvalid = 1'b0;
        @(negedge clk);
        check("late rvalid ignored read_data_w", rdat_w32, 32'h0);
        check("late rvalid ignored valid_w", valid_w32, 1'b0);
        @(posedge clk); #1;
        do_load(1'b0, 3'b010, 64'h300, 64'h0000_1234, 5'd3, 0, 0, 64'h300, 8'h0F, 64'h0000_1234);

        // XLEN=64
        do_load(1'b1, 3'b110, 64'h1004, 64'hFEDC_BA98_0000_0000, 5'd15, 0, 1, 64'h1000, 8'hF0,
                64'h0000_0000_FEDC_BA98);
        do_load(1'b1, 3'b010, 64'h1004, 64'hFEDC_BA98_0000_0000, 5'd16, 1, 0, 64'h1000, 8'hF0,
                64'hFFFF_FFFF_FEDC_BA98);
        do_load(1'b1, 3'b011, 64'h1008, 64'h8877_6655_4433_2211, 5'd17, 0, 0, 64'h1008, 8'hFF,
                64'h8877_6655_4433_2211);
        do_load(1'b1, 3'b000, 64'h1007, 64'h7F00_0000_0000_0000, 5'd18, 0, 0, 64'h1000, 8'h80,
                64'h0000_0000_0000_007F);
        do_store(1'b1, 3'b011, 64'h1000, 64'h0123_4567_89AB_CDEF, 1, 64'h1000, 8'hFF,
                 64'h0123_4567_89AB_CDEF);
        do_store(1'b1, 3'b010, 64'h100C, 64'h0000_0000_CAFE_F00D, 0, 64'h1008, 8'hF0,
                 64'hCAFE_F00D_CAFE_F00D);
        do_fault(1'b1, 1'b0, 1'b1, 3'b011, 64'h1004, 5'd19);
        do_fault(1'b1, 1'b1, 1'b0, 3'b001, 64'h1003, 5'd20);

        repeat (3) @(posedge clk);
        #1;
        check("bus32 queue drained", bq32.size(), 0);
        check("w32 queue drained", wq32.size(), 0);
        check("bus64 queue drained", bq64.size(), 0);
        check("w64 queue drained", wq64.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_memory_lsu.md
Name: riscv_memory_lsu

Overview:
- Parametrised next-generation pipelined memory stage for the RISC-V core.
- Replaces the single-cycle data-memory hookup with a request/grant/response bus, so data memories with variable latency can be used.
- Adds byte-lane generation and load extension for XLEN 32 or 64.
- Detects misaligned and illegal accesses, stalls the M stage, and contains the MEM/WB pipeline register with bubble insertion.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- AW, 32, bus address width; must be ≤ XLEN.
- NB, XLEN/8, byte lanes per bus word (derived; do not override).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_valid_m  in  1  M-stage instruction valid
- i_reg_write_m  in  1  register-write control
- i_result_src_m  in  2  writeback source select
- i_mem_read_m  in  1  load
- i_mem_write_m  in  1  store
- i_funct3_m  in  3  access size/sign
- i_alu_result_m  in  XLEN  effective address
- i_write_data_m  in  XLEN  store data
- i_rd_m  in  5  destination register
- i_pc_plus_4m  in  XLEN  PC+4
- i_ext_imm_m  in  XLEN  extended immediate
- o_stall_m  out  1  hold IF/ID/EX/M
- o_bus_req  out  1  bus request
- o_bus_wen  out  1  1 = write
- o_bus_addr  out  AW  word-aligned address (low log2(NB) bits zero)
- o_bus_wdata  out  XLEN  lane-replicated store data
- o_bus_be  out  NB  byte enables
- i_bus_gnt  in  1  request accepted
- i_bus_rvalid  in  1  read data valid
- i_bus_rdata  in  XLEN  read data
- o_valid_w, o_reg_write_w, o_fault_w  out  1 each  W-stage flags
- o_result_src_w  out  2  W-stage writeback source
- o_alu_result_w, o_read_data_w, o_pc_plus_4w, o_ext_imm_w  out  XLEN each  W-stage data
- o_rd_w  out  5  W-stage destination register

Behaviour:
- Clock/reset: one clock i_clk; reset i_rst is synchronous and active-high.
- Reset values:
  - FSM goes to IDLE.
  - Every o_*_w output resets to 0.
  - o_bus_req and o_stall_m are forced to 0 while i_rst=1.
- Size decode from funct3[1:0]: 00 = byte, 01 = half, 10 = word, 11 = dword.
- funct3 legality:
  - 011 (LD/SD) and 110 (LWU) are legal only when XLEN=64.
  - 111 is always illegal.
- Fault condition: access = i_valid_m & (mem_read | mem_write). An access faults when any of the following holds:
  - funct3 is illegal;
  - half with addr[0] ≠ 0;
  - word with addr[1:0] ≠ 0;
  - dword with addr[2:0] ≠ 0.
- Fault handling: a faulting access issues no bus request and no stall. It is registered to W with o_fault_w=1 and o_reg_write_w=0.
- Lane offset: off = addr[log2(NB)-1:0].
- Byte enables: byte = 1<<off; half = 3<<off; word = 0xF<<off; dword = all ones.
- Store data: wdata replicates the low byte, half or word across all lanes.
- FSM states:
  - IDLE:
    - When a good (non-faulting) access is present, o_bus_req=1 combinationally; o_bus_wen = mem_write; addr, be and wdata are driven from the M inputs.
    - Store: i_bus_gnt=1 completes the access; o_stall_m=0 that cycle; stay in IDLE.
    - Load: i_bus_gnt=1 moves to RESP; o_stall_m=1.
    - No grant: hold the request with identical fields; o_stall_m=1.
    - i_bus_rvalid is ignored in IDLE.
  - RESP:
    - o_bus_req=0.
    - o_stall_m=1 until i_bus_rvalid=1. In that cycle o_stall_m=0, W captures the extended data, and the FSM returns to IDLE.
    - i_bus_rvalid may arrive no earlier than the cycle after the grant.
- Load extension:
  - Select lane data = rdata >> (8·off).
  - LB/LH/LW sign-extend to XLEN.
  - LBU/LHU/LWU zero-extend.
  - LD passes through.
- MEM/WB register:
  - o_stall_m=0: latch all M fields. o_read_data_w = extended load data, or 0 for non-loads. o_valid_w = i_valid_m.
  - o_stall_m=1: insert a bubble; o_valid_w=0, o_reg_write_w=0, o_fault_w=0; other W outputs hold.
  - i_valid_m=0: W receives a bubble with o_reg_write_w=0.
- Reset mid-RESP: return to IDLE and drop the outstanding load; a late rvalid is then ignored.
- Latency: store = 1 cycle with a same-cycle grant; load = 1 + gnt wait + rvalid wait.

Test Plan:
- XLEN=32: LW at 0x100; gnt in cycle 0, rvalid in cycle 2 with rdata 0x8000_00F0.
  - Required: o_stall_m high for cycles 0–1; o_read_data_w=0x8000_00F0 the cycle after rvalid.
  - Required: a bubble in W during the stalled cycles.
- XLEN=32: LB at 0x103 with rdata 0x8012_3456 → o_read_data_w=0xFFFF_FF80.
  - Same access as LBU → 0x0000_0080.
- XLEN=32: SH at 0x102, data 0x0000_ABCD, gnt held low 3 cycles.
  - Required: o_bus_req stable for 4 cycles with be=4'b1100, wdata=0xABCD_ABCD, addr=0x100; o_stall_m high for 3 cycles.
- XLEN=32: LW at 0x102 → no o_bus_req, no stall, o_fault_w=1, o_reg_write_w=0. LD (funct3 011) at 0x100 → fault.
- XLEN=64: LWU at 0x1004 with rdata 0xFEDC_BA98_0000_0000 → o_read_data_w=0x0000_0000_FEDC_BA98.
  - SD at 0x1000 → be=8'hFF.
- Reset: assert i_rst in RESP, then deassert and drive rvalid.
  - Required: FSM in IDLE, all W outputs 0, the rvalid ignored, and the next LW completes normally.
